// File: rtl/noc_packetizer_if.sv
// Injection-side bus for noc_packetizer: packet command, payload stream and the flit link
// toward the node receive port. slave = packetizer, master = its surroundings.
interface noc_packetizer_if #(
    parameter int unsigned FLIT_W  = 32,
    parameter int unsigned COORD_W = 1,
    parameter int unsigned LEN_W   = 8
);
    logic               cmd_valid;
    logic               cmd_ready;
    logic [COORD_W-1:0] cmd_dst_x;
    logic [COORD_W-1:0] cmd_dst_y;
    logic [LEN_W-1:0]   cmd_len;
    logic               data_valid;
    logic               data_ready;
    logic [FLIT_W-1:0]  data_in;
    logic               out_valid;
    logic               out_ready;
    logic [FLIT_W-1:0]  out_flit;
    logic               out_is_header;
    logic               out_is_tail;

    modport master (
        output cmd_valid, cmd_dst_x, cmd_dst_y, cmd_len, data_valid, data_in, out_ready,
        input  cmd_ready, data_ready, out_valid, out_flit, out_is_header, out_is_tail
    );

    modport slave (
        input  cmd_valid, cmd_dst_x, cmd_dst_y, cmd_len, data_valid, data_in, out_ready,
        output cmd_ready, data_ready, out_valid, out_flit, out_is_header, out_is_tail
    );
endinterface

// File: rtl/noc_packetizer.sv
// NoC injection stage: turns (dst, len) commands plus payload words into header/body flits.
// Optional NOC_PKT_CRC_EN appends an XOR-of-body flit as the packet tail.
module noc_packetizer #(
    parameter int unsigned FLIT_W  = 32,
    parameter int unsigned COORD_W = 1,
    parameter int unsigned LEN_W   = 8,
    parameter int unsigned SRC_X   = 0,
    parameter int unsigned SRC_Y   = 0
) (
    input  logic            noc_clk,
    input  logic            noc_rst_n,
    noc_packetizer_if.slave link,
    output logic            busy,
    output logic [15:0]     pkt_count
);

`ifdef NOC_PKT_CRC_EN
    typedef enum logic [1:0] {IDLE, BODY, CRC} state_e;
`else
    typedef enum logic [1:0] {IDLE, BODY} state_e;
`endif

    state_e             state_q, state_d;
    logic               out_valid_q, out_valid_d;
    logic [FLIT_W-1:0]  out_flit_q, out_flit_d;
    logic               out_hdr_q, out_hdr_d;
    logic               out_tail_q, out_tail_d;
    logic [LEN_W-1:0]   rem_q, rem_d;
    logic [15:0]        cnt_q, cnt_d;
    logic               run_q;
`ifdef NOC_PKT_CRC_EN
    logic [FLIT_W-1:0]  crc_q, crc_d;
`endif

    logic               free_c;
    logic               cmd_ready_c;
    logic               data_ready_c;
    logic [FLIT_W-1:0]  hdr_c;

    // Header: dst_x, dst_y, src_x, src_y from the MSB down, length in the low bits.
    always_comb begin
        hdr_c = '0;
        hdr_c[FLIT_W-1 -: COORD_W]           = link.cmd_dst_x;
        hdr_c[FLIT_W-1-COORD_W -: COORD_W]   = link.cmd_dst_y;
        hdr_c[FLIT_W-1-2*COORD_W -: COORD_W] = COORD_W'(SRC_X);
        hdr_c[FLIT_W-1-3*COORD_W -: COORD_W] = COORD_W'(SRC_Y);
        hdr_c[LEN_W-1:0]                     = link.cmd_len;
    end

    // Next-state and output-register load logic.
    always_comb begin
        state_d      = state_q;
        out_valid_d  = out_valid_q;
        out_flit_d   = out_flit_q;
        out_hdr_d    = out_hdr_q;
        out_tail_d   = out_tail_q;
        rem_d        = rem_q;
        cnt_d        = cnt_q;
`ifdef NOC_PKT_CRC_EN
        crc_d        = crc_q;
`endif
        cmd_ready_c  = 1'b0;
        data_ready_c = 1'b0;
        free_c       = !out_valid_q || link.out_ready;

        if (out_valid_q && link.out_ready) begin
            out_valid_d = 1'b0;
            if (out_tail_q) begin
                cnt_d = cnt_q + 16'd1;
            end
        end

        case (state_q)
            IDLE: begin
                // run_q keeps cmd_ready low until the first edge after reset release
                cmd_ready_c = run_q && free_c;
                if (cmd_ready_c && link.cmd_valid) begin
                    out_valid_d = 1'b1;
                    out_flit_d  = hdr_c;
                    out_hdr_d   = 1'b1;
                    rem_d       = link.cmd_len;
`ifdef NOC_PKT_CRC_EN
                    crc_d       = '0;
                    out_tail_d  = 1'b0;
                    state_d     = (link.cmd_len == LEN_W'(0)) ? CRC : BODY;
`else
                    out_tail_d  = (link.cmd_len == LEN_W'(0));
                    state_d     = (link.cmd_len == LEN_W'(0)) ? IDLE : BODY;
`endif
                end
            end
            BODY: begin
                data_ready_c = free_c;
                if (data_ready_c && link.data_valid) begin
                    out_valid_d = 1'b1;
                    out_flit_d  = link.data_in;
                    out_hdr_d   = 1'b0;
                    rem_d       = rem_q - LEN_W'(1);
`ifdef NOC_PKT_CRC_EN
                    crc_d       = crc_q ^ link.data_in;
                    out_tail_d  = 1'b0;
                    if (rem_q == LEN_W'(1)) begin
                        state_d = CRC;
                    end
`else
                    out_tail_d  = (rem_q == LEN_W'(1));
                    if (rem_q == LEN_W'(1)) begin
                        state_d = IDLE;
                    end
`endif
                end
            end
`ifdef NOC_PKT_CRC_EN
            CRC: begin
                if (free_c) begin
                    out_valid_d = 1'b1;
                    out_flit_d  = crc_q;
                    out_hdr_d   = 1'b0;
                    out_tail_d  = 1'b1;
                    state_d     = IDLE;
                end
            end
`endif
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge noc_clk or negedge noc_rst_n) begin
        if (!noc_rst_n) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            out_flit_q  <= '0;
            out_hdr_q   <= 1'b0;
            out_tail_q  <= 1'b0;
            rem_q       <= '0;
            cnt_q       <= '0;
            run_q       <= 1'b0;
`ifdef NOC_PKT_CRC_EN
            crc_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            out_flit_q  <= out_flit_d;
            out_hdr_q   <= out_hdr_d;
            out_tail_q  <= out_tail_d;
            rem_q       <= rem_d;
            cnt_q       <= cnt_d;
            run_q       <= 1'b1;
`ifdef NOC_PKT_CRC_EN
            crc_q       <= crc_d;
`endif
        end
    end

    assign link.cmd_ready     = cmd_ready_c;
    assign link.data_ready    = data_ready_c;
    assign link.out_valid     = out_valid_q;
    assign link.out_flit      = out_flit_q;
    assign link.out_is_header = out_hdr_q;
    assign link.out_is_tail   = out_tail_q;
    assign busy               = (state_q != IDLE) || out_valid_q;
    assign pkt_count          = cnt_q;

endmodule

// File: tb/tb_noc_packetizer.sv
// Bench for noc_packetizer: directed table, hand sequences and random traffic against a
// flit-queue reference model built from the packet framing rules.
`timescale 1ns/1ps
module tb_noc_packetizer;
    localparam int unsigned FLIT_W  = 32;
    localparam int unsigned COORD_W = 1;
    localparam int unsigned LEN_W   = 8;
    localparam int unsigned SRC_X   = 0;
    localparam int unsigned SRC_Y   = 0;
`ifdef NOC_PKT_CRC_EN
    localparam bit CRC = 1'b1;
`else
    localparam bit CRC = 1'b0;
`endif

    typedef struct packed {
        logic [31:0] flit;
        logic        hdr;
        logic        tail;
    } exp_t;

    typedef struct {
        logic        dx;
        logic        dy;
        logic [7:0]  len;
        logic [31:0] base;
        logic [31:0] hdr;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        busy;
    logic [15:0] pkt_count;

    noc_packetizer_if #(.FLIT_W(FLIT_W), .COORD_W(COORD_W), .LEN_W(LEN_W)) bus ();

    noc_packetizer #(
        .FLIT_W(FLIT_W), .COORD_W(COORD_W), .LEN_W(LEN_W), .SRC_X(SRC_X), .SRC_Y(SRC_Y)
    ) dut (
        .noc_clk(clk),
        .noc_rst_n(rst_n),
        .link(bus),
        .busy(busy),
        .pkt_count(pkt_count)
    );

    always #5 clk = ~clk;

    int          n_vec = 0;
    int          n_err = 0;
    exp_t        exp_q[$];
    logic [33:0] seen_q[$];
    int          body_left = 0;
    logic [31:0] crc_acc = '0;
    int          model_pkts = 0;
    int          exp_total = 0;
    bit          prev_stall = 1'b0;
    logic [31:0] prev_flit = '0;
    logic [1:0]  prev_flags = '0;
    bit          load_pend = 1'b0;
    bit          cmd_hs = 1'b0;
    bit          data_hs = 1'b0;
    vec_t        tbl[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, expv, $time);
        end
    endtask

    task automatic fail(input string name);
        n_vec++;
        n_err++;
        $display("FAIL %s: got no event, expected event within bound at %0t", name, $time);
    endtask

    // One clock cycle: called at a falling edge with inputs already driven.
    task automatic step();
        exp_t        e;
        logic [31:0] h;
        #1;
        cmd_hs  = bus.cmd_valid && bus.cmd_ready;
        data_hs = bus.data_valid && bus.data_ready;
        if (prev_stall) begin
            check("hold_valid", 32'(bus.out_valid), 32'd1);
            check("hold_flit", bus.out_flit, prev_flit);
            check("hold_flags", 32'({bus.out_is_header, bus.out_is_tail}), 32'(prev_flags));
        end
        if (load_pend) check("latency_valid", 32'(bus.out_valid), 32'd1);
        check("dready_outside_body", 32'(bus.data_ready && body_left == 0), 32'd0);
        check("cready_inside_body", 32'(bus.cmd_ready && body_left != 0), 32'd0);
        if (bus.out_valid && bus.out_ready) begin
            seen_q.push_back({bus.out_is_header, bus.out_is_tail, bus.out_flit});
            if (exp_q.size() == 0) fail("unexpected_flit");
            else begin
                e = exp_q.pop_front();
                check("flit", bus.out_flit, e.flit);
                check("flags", 32'({bus.out_is_header, bus.out_is_tail}), 32'({e.hdr, e.tail}));
                if (e.tail) model_pkts++;
            end
        end
        if (cmd_hs) begin
            h = (32'(bus.cmd_dst_x) << 31) | (32'(bus.cmd_dst_y) << 30) |
                (32'(SRC_X) << 29) | (32'(SRC_Y) << 28) | 32'(bus.cmd_len);
            exp_q.push_back('{flit: h, hdr: 1'b1, tail: (bus.cmd_len == 8'd0) && !CRC});
            if (bus.cmd_len == 8'd0 && CRC) exp_q.push_back('{flit: 32'h0, hdr: 1'b0, tail: 1'b1});
            body_left = int'(bus.cmd_len);
            crc_acc   = '0;
        end
        if (data_hs) begin
            crc_acc = crc_acc ^ bus.data_in;
            body_left--;
            exp_q.push_back('{flit: bus.data_in, hdr: 1'b0, tail: (body_left == 0) && !CRC});
            if (body_left == 0 && CRC) exp_q.push_back('{flit: crc_acc, hdr: 1'b0, tail: 1'b1});
        end
        load_pend  = cmd_hs || data_hs;
        prev_stall = bus.out_valid && !bus.out_ready;
        prev_flit  = bus.out_flit;
        prev_flags = {bus.out_is_header, bus.out_is_tail};
        @(negedge clk);
    endtask

    task automatic send_pkt(input logic dx, input logic dy, input logic [7:0] len,
                            input logic [31:0] base, input bit rnd,
                            output int wait_cmd, output int body_cyc);
        int sent;
        bit ok;
        wait_cmd = 0;
        body_cyc = 0;
        sent     = 0;
        ok       = 1'b0;
        bus.cmd_dst_x = dx;
        bus.cmd_dst_y = dy;
        bus.cmd_len   = len;
        do begin
            bus.cmd_valid  = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            bus.data_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
            bus.data_in    = $urandom;
            if (rnd) bus.out_ready = ($urandom_range(0, 3) != 0);
            step();
            wait_cmd++;
            ok = cmd_hs;
        end while (!ok && wait_cmd < 200);
        if (!ok) fail("cmd_accept_timeout");
        bus.cmd_valid = 1'b0;
        while (ok && sent < int'(len) && body_cyc < 2000) begin
            bus.cmd_valid  = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
            bus.data_valid = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            if (bus.data_valid) bus.data_in = base + 32'(sent);
            else                bus.data_in = $urandom;
            if (rnd) bus.out_ready = ($urandom_range(0, 3) != 0);
            step();
            body_cyc++;
            if (data_hs) sent++;
        end
        if (sent < int'(len)) fail("body_accept_timeout");
        bus.cmd_valid  = 1'b0;
        bus.data_valid = 1'b0;
    endtask

    task automatic drain(input bit rnd);
        int n;
        n = 0;
        bus.cmd_valid  = 1'b0;
        bus.data_valid = 1'b0;
        while ((exp_q.size() != 0 || bus.out_valid) && n < 500) begin
            bus.out_ready = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
            step();
            n++;
        end
        if (exp_q.size() != 0 || bus.out_valid) fail("drain_timeout");
        bus.out_ready = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish, expected finish before 500us");
        $fatal(1, "watchdog");
    end

    initial begin
        int wc, bc, k;
        tbl[0] = '{1'b1, 1'b1, 8'd3,   32'h0000_000A, 32'hC000_0003};
        tbl[1] = '{1'b1, 1'b0, 8'd0,   32'h0,         32'h8000_0000};
        tbl[2] = '{1'b0, 1'b1, 8'd2,   32'h0000_0100, 32'h4000_0002};
        tbl[3] = '{1'b0, 1'b0, 8'd1,   32'hDEAD_0000, 32'h0000_0001};
        tbl[4] = '{1'b1, 1'b1, 8'd255, 32'h1234_0000, 32'hC000_00FF};
        tbl[5] = '{1'b0, 1'b0, 8'd0,   32'h0,         32'h0000_0000};

        rst_n = 1'b0;
        bus.cmd_valid = 1'b0; bus.cmd_dst_x = '0; bus.cmd_dst_y = '0; bus.cmd_len = '0;
        bus.data_valid = 1'b0; bus.data_in = '0; bus.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_out_flit", bus.out_flit, 32'd0);
        check("rst_flags", 32'({bus.out_is_header, bus.out_is_tail}), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_pkt_count", 32'(pkt_count), 32'd0);
        check("rst_cmd_ready", 32'(bus.cmd_ready), 32'd0);
        check("rst_data_ready", 32'(bus.data_ready), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b1;
        #1;
        check("idle_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        check("idle_busy", 32'(busy), 32'd0);
        @(negedge clk);

        // Reset in the middle of a 4-flit body
        bus.cmd_valid = 1'b1; bus.cmd_dst_x = 1'b1; bus.cmd_dst_y = 1'b1; bus.cmd_len = 8'd4;
        step();
        check("mbr_cmd_hs", 32'(cmd_hs), 32'd1);
        bus.cmd_valid = 1'b0; bus.data_valid = 1'b1; bus.data_in = 32'h11;
        step();
        check("mbr_data_hs", 32'(data_hs), 32'd1);
        bus.data_valid = 1'b0;
        check("mbr_busy_before", 32'(busy), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("mbr_out_valid", 32'(bus.out_valid), 32'd0);
        check("mbr_busy", 32'(busy), 32'd0);
        check("mbr_pkt_count", 32'(pkt_count), 32'd0);
        check("mbr_data_ready", 32'(bus.data_ready), 32'd0);
        exp_q.delete(); body_left = 0; prev_stall = 1'b0; load_pend = 1'b0;
        model_pkts = 0; exp_total = 0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed table, back-to-back with out_ready high
        seen_q.delete();
        foreach (tbl[i]) begin
            send_pkt(tbl[i].dx, tbl[i].dy, tbl[i].len, tbl[i].base, 1'b0, wc, bc);
            check("tbl_body_cycles", 32'(bc), 32'(tbl[i].len));
`ifndef NOC_PKT_CRC_EN
            check("tbl_cmd_wait", 32'(wc), 32'd1);
`endif
            exp_total++;
        end
        drain(1'b0);
        k = 0;
        foreach (seen_q[j]) begin
            if (seen_q[j][33]) begin
                if (k < 6) check("tbl_header", seen_q[j][31:0], tbl[k].hdr);
                k++;
            end
        end
        check("tbl_header_count", 32'(k), 32'd6);
`ifndef NOC_PKT_CRC_EN
        check("tbl0_flit0", 32'(seen_q[0]), 32'(34'h2_C000_0003));
        check("tbl0_flit1", 32'(seen_q[1]), 32'h0000_000A);
        check("tbl0_flit2", 32'(seen_q[2]), 32'h0000_000B);
        check("tbl0_tailflag", 32'(seen_q[3][33:32]), 32'd1);
        check("tbl1_hdr_tail", 32'(seen_q[4][33:32]), 32'd3);
`endif
        check("tbl_pkt_count", 32'(pkt_count), 32'(exp_total));

        // Back-pressure during the first body flit
        seen_q.delete();
        bus.out_ready = 1'b1;
        bus.cmd_valid = 1'b1; bus.cmd_dst_x = 1'b1; bus.cmd_dst_y = 1'b0; bus.cmd_len = 8'd2;
        step();
        check("stall_cmd_hs", 32'(cmd_hs), 32'd1);
        bus.cmd_valid = 1'b0; bus.data_valid = 1'b1; bus.data_in = 32'h55;
        step();
        bus.out_ready = 1'b0; bus.data_in = 32'h66;
        for (int s = 0; s < 3; s++) begin
            #1;
            check("stall_data_ready", 32'(bus.data_ready), 32'd0);
            check("stall_flit", bus.out_flit, 32'h55);
            step();
        end
        bus.out_ready = 1'b1;
        k = 0;
        do begin step(); k++; end while (!data_hs && k < 10);
        if (!data_hs) fail("stall_resume_timeout");
        drain(1'b0);
        exp_total++;
        check("stall_flit_count", 32'(seen_q.size()), CRC ? 32'd4 : 32'd3);
        check("stall_body1", 32'(seen_q[1]), 32'h55);
        check("stall_body2", seen_q[2][31:0], 32'h66);
        check("stall_pkt_count", 32'(pkt_count), 32'(exp_total));

`ifdef NOC_PKT_CRC_EN
        seen_q.delete();
        bus.cmd_valid = 1'b1; bus.cmd_dst_x = 1'b0; bus.cmd_dst_y = 1'b0; bus.cmd_len = 8'd2;
        step();
        bus.cmd_valid = 1'b0; bus.data_valid = 1'b1; bus.data_in = 32'h0F;
        step();
        bus.data_in = 32'hF1;
        step();
        drain(1'b0);
        exp_total++;
        check("crc_flit_count", 32'(seen_q.size()), 32'd4);
        check("crc_hdr", 32'(seen_q[0]), 32'h0000_0002);
        check("crc_last_body", 32'(seen_q[2][33:0]), 32'h0000_00F1);
        check("crc_last_body_flags", 32'(seen_q[2][33:32]), 32'd0);
        check("crc_flit", seen_q[3][31:0], 32'h0000_00FE);
        check("crc_flit_flags", 32'(seen_q[3][33:32]), 32'd1);
        check("crc_pkt_count", 32'(pkt_count), 32'(exp_total));
`endif

        // Random traffic with random back-pressure and idle-side noise
        for (int p = 0; p < 40; p++) begin
            send_pkt(1'($urandom), 1'($urandom),
                     (p % 10 == 9) ? 8'd20 : 8'($urandom_range(0, 6)),
                     $urandom, 1'b1, wc, bc);
            exp_total++;
        end
        drain(1'b1);
        check("rand_pkt_count", 32'(pkt_count), 32'(exp_total));
        check("rand_model_count", 32'(pkt_count), 32'(model_pkts));
        check("rand_busy_end", 32'(busy), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/noc_packetizer.md
Name: noc_packetizer

Overview:
Network-interface injection stage that sits directly upstream of a mesh node's receive port (Noc_x_y_receive_*).
- Accepts a packet command (destination, length) and a stream of payload words.
- Emits a header flit, then the body flits, with is_header/is_tail framing on a valid/ready link.
- One instance per mesh node; its output port wires straight to that node's receive_* inputs.

Parameters:
FLIT_W, 32, flit and payload width in bits
COORD_W, 1, width of each X/Y mesh coordinate
LEN_W, 8, width of the body-length field
SRC_X, 0, X coordinate of the owning node
SRC_Y, 0, Y coordinate of the owning node

Ports:
noc_clk  input  1  clock; all logic rises on this edge
noc_rst_n  input  1  reset; asynchronous assert, active-low
cmd_valid  input  1  packet command valid
cmd_ready  output  1  packet command accepted when high with cmd_valid
cmd_dst_x  input  COORD_W  destination X coordinate
cmd_dst_y  input  COORD_W  destination Y coordinate
cmd_len  input  LEN_W  number of body flits (0 allowed)
data_valid  input  1  payload word valid
data_ready  output  1  payload word accepted
data_in  input  FLIT_W  payload word
out_valid  output  1  flit valid toward the node receive port
out_ready  input  1  node receive port ready
out_flit  output  FLIT_W  flit
out_is_header  output  1  flit is the header
out_is_tail  output  1  flit is the last flit of the packet
busy  output  1  high while a packet is mid-emission (state != IDLE or out_valid)
pkt_count  output  16  packets fully sent (tail handshakes), wraps 0xFFFF->0

Behaviour:
- Reset (noc_rst_n low, asynchronous): state=IDLE; out_valid, out_is_header, out_is_tail, busy, cmd_ready, data_ready all 0; out_flit=0; pkt_count=0; remaining-count=0. A reset mid-packet drops the packet silently and does not emit a tail.
- Single output register; define free = !out_valid || out_ready.
- Output hold rule: out_valid, out_flit and the flags stay stable while out_valid && !out_ready.
- Header flit layout, MSB first: dst_x[COORD_W], dst_y[COORD_W], SRC_X[COORD_W], SRC_Y[COORD_W], zero padding, then cmd_len in bits [LEN_W-1:0].
- State IDLE:
  - cmd_ready = free.
  - On cmd handshake: the output register loads the header with out_is_header=1 on the next edge; remaining is set to cmd_len.
  - If cmd_len==0, out_is_tail=1 on the same flit (header and tail together) and the state stays IDLE.
  - Otherwise the state goes to BODY.
- State BODY:
  - data_ready = free; cmd_ready = 0.
  - Each data handshake loads data_in with out_is_header=0 and decrements remaining.
  - When remaining==1 at the handshake, out_is_tail=1 and the state returns to IDLE.
- Latency: one cycle from an input handshake to out_valid. Throughput is 1 flit/cycle with out_ready held high; back-to-back packets need no bubble.
- data_valid while in IDLE is ignored (data_ready=0). cmd_valid while in BODY is held off.
- pkt_count increments on the edge where out_valid && out_ready && out_is_tail.
- If no new load occurs on an output handshake, out_valid drops to 0 on the next edge.

Optional Feature:
NOC_PKT_CRC_EN:
- Defined:
  - The block keeps a running XOR of all body words of the current packet; it is cleared at each cmd handshake.
  - After the last body flit it adds state CRC, which loads the XOR as an extra flit (is_tail=1) when free. The last body flit then has is_tail=0.
  - A len==0 packet emits the header (is_tail=0) followed by a CRC flit of 0.
  - The header length field still holds cmd_len, excluding the CRC flit.
- Undefined: no CRC logic, no CRC state; framing is exactly as in Behaviour.

Test Plan:
- Reset then idle -> all outputs 0, cmd_ready=1 once out_valid is 0, pkt_count=0.
- SRC=(0,0), cmd dst=(1,1), len=3, data 0xA,0xB,0xC, out_ready=1 -> flits 0xC0000003(hdr), 0xA, 0xB, 0xC(tail) on 4 consecutive cycles; pkt_count=1.
- cmd len=0, dst=(1,0) -> single flit 0x80000000 with is_header=1 and is_tail=1; the next cmd is accepted the following cycle.
- len=2, out_ready low for 3 cycles during the first body flit -> flit and flags held, data_ready=0, no data lost, tail delivered after out_ready rises.
- Assert reset mid-BODY after 1 of 4 body flits -> out_valid=0 immediately, state IDLE, pkt_count unchanged, next packet framed correctly.
- NOC_PKT_CRC_EN, len=2, data 0x0F,0xF1 -> hdr, 0x0F, 0xF1(is_tail=0), 0xFE(is_tail=1); pkt_count increments once.
